// File: rtl/game_pkg.sv
// Shared definitions for the snake game score path.
package game_pkg;

    // Score bus width feeding the digit selector
    localparam int unsigned SCORE_W       = 8;
    // Default saturation value; the display path shows 0..69
    localparam int unsigned DEF_MAX_SCORE = 69;

    // Game FSM states; the unused 2'd3 pattern decodes to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

endpackage

// File: rtl/edge_lockout.sv
// Rising-edge detect on the eat level with a post-acceptance lockout window.
module edge_lockout #(
    parameter int unsigned LOCKOUT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_eat,
    input  logic i_en,
    input  logic i_clr,
    output logic o_eat_ok
);

    localparam int unsigned CNT_W = (LOCKOUT == 0) ? 1 : $clog2(LOCKOUT + 1);
    localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOCKOUT);

    logic             r_eat_d;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;

    assign w_rise   = i_eat & ~r_eat_d;
    assign o_eat_ok = w_rise & i_en & (r_cnt == '0);

    // Track eat every cycle; load lockout on acceptance, else count down to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eat_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_eat_d <= i_eat;
            if (i_clr) begin
                r_cnt <= '0;
            end else if (o_eat_ok) begin
                r_cnt <= LOAD_V;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game score counter with saturation, session high score and game FSM.
module score_keeper #(
    parameter int unsigned MAX_SCORE = game_pkg::DEF_MAX_SCORE,
    parameter int unsigned LOCKOUT   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         eat,
    input  logic                         game_over,
    output logic [game_pkg::SCORE_W-1:0] outscore,
    output logic [game_pkg::SCORE_W-1:0] high_score,
    output logic                         new_high,
    output logic                         saturated,
    output logic                         playing
);

    import game_pkg::*;

    localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);

    game_state_t        r_state;
    game_state_t        w_state_nx;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_score_nx;
    logic [SCORE_W-1:0] r_high;
    logic [SCORE_W-1:0] w_high_nx;
    logic [SCORE_W-1:0] w_score_inc;
    logic               r_new_high;
    logic               w_new_high_nx;
    logic               w_in_play;
    logic               w_eat_ok;
    logic               w_lock_clr;

    assign w_in_play   = (r_state == ST_PLAY);
    assign w_score_inc = (r_score == MAX_V) ? r_score : r_score + SCORE_W'(1);

    edge_lockout #(
        .LOCKOUT(LOCKOUT)
    ) u_edge_lockout (
        .clk     (clk),
        .rst     (rst),
        .i_eat   (eat),
        .i_en    (w_in_play),
        .i_clr   (w_lock_clr),
        .o_eat_ok(w_eat_ok)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Score, high score and new-high flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_score    <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
        end else begin
            r_score    <= w_score_nx;
            r_high     <= w_high_nx;
            r_new_high <= w_new_high_nx;
        end
    end

    // Next state and datapath; in PLAY start beats game_over, and an eat that
    // coincides with game_over is counted before the high-score compare
    always_comb begin
        w_state_nx    = r_state;
        w_score_nx    = r_score;
        w_high_nx     = r_high;
        w_new_high_nx = r_new_high;
        w_lock_clr    = 1'b0;
        case (r_state)
            ST_PLAY: begin
                if (start) begin
                    w_score_nx    = '0;
                    w_new_high_nx = 1'b0;
                    w_lock_clr    = 1'b1;
                end else begin
                    if (w_eat_ok) begin
                        w_score_nx = w_score_inc;
                    end
                    if (game_over) begin
                        w_state_nx = ST_OVER;
                        if (w_score_nx > r_high) begin
                            w_high_nx     = w_score_nx;
                            w_new_high_nx = 1'b1;
                        end
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    w_state_nx    = ST_PLAY;
                    w_score_nx    = '0;
                    w_new_high_nx = 1'b0;
                    w_lock_clr    = 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                if (start) begin
                    w_state_nx    = ST_PLAY;
                    w_score_nx    = '0;
                    w_new_high_nx = 1'b0;
                    w_lock_clr    = 1'b1;
                end
            end
        endcase
    end

    assign outscore   = r_score;
    assign high_score = r_high;
    assign new_high   = r_new_high;
    assign saturated  = (r_score == MAX_V);
    assign playing    = w_in_play;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus a random run
// compared cycle by cycle against a timestamp-based game model.
module tb_score_keeper;

    localparam int MAXS = 69;
    localparam int LOCK = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       eat = 1'b0;
    logic       game_over = 1'b0;
    logic [7:0] outscore;
    logic [7:0] high_score;
    logic       new_high;
    logic       saturated;
    logic       playing;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: game rules with lockout tracked as "time of last accept"
    int  cyc       = 0;
    int  m_last    = -1000;
    int  m_score   = 0;
    int  m_high    = 0;
    bit  m_newhigh = 1'b0;
    bit  m_play    = 1'b0;
    bit  m_eat_d   = 1'b0;

    logic [18:0] dut_obs;
    assign dut_obs = {outscore, high_score, new_high, saturated, playing};

    score_keeper #(
        .MAX_SCORE(MAXS),
        .LOCKOUT  (LOCK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .eat       (eat),
        .game_over (game_over),
        .outscore  (outscore),
        .high_score(high_score),
        .new_high  (new_high),
        .saturated (saturated),
        .playing   (playing)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] model_obs();
        return {8'(m_score), 8'(m_high), m_newhigh, (m_score == MAXS), m_play};
    endfunction

    task automatic model_edge(input bit s, input bit e, input bit g, input bit r);
        bit rise;
        bit acc;
        cyc++;
        if (r) begin
            m_last = -1000; m_score = 0; m_high = 0; m_newhigh = 0;
            m_play = 0; m_eat_d = 0;
        end else begin
            rise    = e && !m_eat_d;
            m_eat_d = e;
            acc     = rise && m_play && (cyc - m_last > LOCK);
            if (m_play) begin
                if (s) begin
                    m_score = 0; m_last = -1000;
                end else begin
                    if (acc) begin
                        m_last = cyc;
                        if (m_score < MAXS) m_score++;
                    end
                    if (g) begin
                        m_play = 0;
                        if (m_score > m_high) begin
                            m_high = m_score; m_newhigh = 1;
                        end
                    end
                end
            end else if (s) begin
                m_play = 1; m_score = 0; m_newhigh = 0; m_last = -1000;
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, settle
    task automatic step(input bit s, input bit e, input bit g, input bit r = 1'b0);
        rst = r; start = s; eat = e; game_over = g;
        @(posedge clk);
        model_edge(s, e, g, r);
        #1;
    endtask

    // Single accepted-width eat pulse followed by enough idle to clear lockout
    task automatic eat_pulse();
        step(0, 1, 0);
        repeat ($urandom_range(9, 5)) step(0, 0, 0);
    endtask

    task automatic test_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        n_checks++;
        if (dut_obs !== 19'd0) begin
            n_errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_obs, 19'd0);
        end
        step(0, 0, 0);
        n_checks++;
        if (dut_obs !== model_obs()) begin
            n_errors++;
            $display("FAIL reset_model got=%h exp=%h", dut_obs, model_obs());
        end
    endtask

    task automatic test_count();
        step(1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            repeat (9) step(0, 0, 0);
            n_checks++;
            if (outscore !== 8'(k - 1)) begin
                n_errors++;
                $display("FAIL count_before_%0d got=%0d exp=%0d", k, outscore, k - 1);
            end
            step(0, 1, 0);
            n_checks++;
            if (outscore !== 8'(k) || playing !== 1'b1) begin
                n_errors++;
                $display("FAIL count_after_%0d got=%0d/%b exp=%0d/1", k, outscore, playing, k);
            end
        end
    endtask

    task automatic test_lockout();
        int base;
        repeat (6) step(0, 0, 0);
        base = m_score;
        repeat (20) step(0, 1, 0);
        n_checks++;
        if (outscore !== 8'(base + 1)) begin
            n_errors++;
            $display("FAIL held_eat got=%0d exp=%0d", outscore, base + 1);
        end
        repeat (6) step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        n_checks++;
        if (outscore !== 8'(base + 2)) begin
            n_errors++;
            $display("FAIL lockout_block got=%0d exp=%0d", outscore, base + 2);
        end
        repeat (6) step(0, 0, 0);
        step(0, 1, 0);
        repeat (5) step(0, 0, 0);
        step(0, 1, 0);
        n_checks++;
        if (outscore !== 8'(base + 4)) begin
            n_errors++;
            $display("FAIL lockout_expire got=%0d exp=%0d", outscore, base + 4);
        end
    endtask

    task automatic test_saturate();
        step(0, 0, 0, 1);
        step(1, 0, 0);
        repeat (68) eat_pulse();
        n_checks++;
        if (outscore !== 8'd68 || saturated !== 1'b0) begin
            n_errors++;
            $display("FAIL sat_68 got=%0d/%b exp=68/0", outscore, saturated);
        end
        eat_pulse();
        n_checks++;
        if (outscore !== 8'd69 || saturated !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_69 got=%0d/%b exp=69/1", outscore, saturated);
        end
        eat_pulse();
        n_checks++;
        if (outscore !== 8'd69 || saturated !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_hold got=%0d/%b exp=69/1", outscore, saturated);
        end
    endtask

    task automatic test_high_score();
        step(0, 0, 0, 1);
        step(1, 0, 0);
        repeat (12) eat_pulse();
        step(0, 0, 1);
        n_checks++;
        if ({outscore, high_score, new_high, playing} !== {8'd12, 8'd12, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL high_first got=%0d/%0d/%b/%b exp=12/12/1/0",
                     outscore, high_score, new_high, playing);
        end
        step(1, 0, 0);
        repeat (5) eat_pulse();
        step(0, 0, 1);
        n_checks++;
        if ({outscore, high_score, new_high, playing} !== {8'd5, 8'd12, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL high_keep got=%0d/%0d/%b/%b exp=5/12/0/0",
                     outscore, high_score, new_high, playing);
        end
    endtask

    task automatic test_simultaneous();
        step(0, 0, 0, 1);
        step(1, 0, 0);
        repeat (7) eat_pulse();
        step(0, 1, 1);
        n_checks++;
        if ({outscore, high_score, new_high, playing} !== {8'd8, 8'd8, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL over_and_eat got=%0d/%0d/%b/%b exp=8/8/1/0",
                     outscore, high_score, new_high, playing);
        end
        repeat (3) step(0, 0, 0);
        step(0, 1, 0);
        n_checks++;
        if (outscore !== 8'd8) begin
            n_errors++;
            $display("FAIL frozen got=%0d exp=8", outscore);
        end
        step(1, 0, 0);
        eat_pulse();
        step(1, 0, 1);
        n_checks++;
        if ({outscore, high_score, playing} !== {8'd0, 8'd8, 1'b1}) begin
            n_errors++;
            $display("FAIL start_beats_over got=%0d/%0d/%b exp=0/8/1",
                     outscore, high_score, playing);
        end
    endtask

    task automatic test_rst_mid_game();
        step(0, 0, 0, 1);
        step(1, 0, 0);
        repeat (40) eat_pulse();
        step(0, 0, 1);
        step(1, 0, 0);
        repeat (30) eat_pulse();
        n_checks++;
        if ({outscore, high_score, playing} !== {8'd30, 8'd40, 1'b1}) begin
            n_errors++;
            $display("FAIL pre_rst got=%0d/%0d/%b exp=30/40/1", outscore, high_score, playing);
        end
        step(0, 0, 0, 1);
        n_checks++;
        if (dut_obs !== 19'd0) begin
            n_errors++;
            $display("FAIL rst_mid got=%h exp=%h", dut_obs, 19'd0);
        end
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        n_checks++;
        if (outscore !== 8'd0 || playing !== 1'b0) begin
            n_errors++;
            $display("FAIL eat_idle got=%0d/%b exp=0/0", outscore, playing);
        end
    endtask

    task automatic test_random();
        bit e;
        e = 1'b0;
        step(0, 0, 0, 1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 35) e = ~e;
            step(($urandom_range(99) < 3), e, ($urandom_range(99) < 3),
                 ($urandom_range(999) < 4));
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_errors++;
                $display("FAIL random_cyc%0d got=%h exp=%h", i, dut_obs, model_obs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_lockout();
        test_saturate();
        test_high_score();
        test_simultaneous();
        test_rst_mid_game();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
